// File: rtl/usr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : usr_cmd_sequencer
//  Purpose  : Command-driven controller for universal_shift_reg. Accepts one
//             handshaked command (hold/read, shift right N, shift left N,
//             parallel load), plays out the per-cycle register controls,
//             then returns the final parallel word and the shifted-out bits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            clock, synchronous active-high reset
//    cmd_valid/ready     command handshake
//    cmd_op              00 hold, 01 shift right, 10 shift left, 11 load
//    cmd_data            load word, or serial fill bits (LSB first)
//    cmd_len             shift count (shift ops only)
//    sel, p_in,
//    s_right_in,
//    s_left_in           controls to the shift register (all registered)
//    p_out, s_right_out,
//    s_left_out          observations from the shift register
//    rsp_valid/ready     response handshake
//    rsp_data            p_out captured after the operation
//    rsp_ser             shifted-out bits, most recent at bit 0
// ============================================================================
module usr_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] p_in,
    output logic             s_right_in,
    output logic             s_left_in,
    input  logic [WIDTH-1:0] p_out,
    input  logic             s_right_out,
    input  logic             s_left_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_ser
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_SHR   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    // One extra bit so a maximum length count cannot wrap.
    localparam logic [CNT_W:0] C_CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

    logic [1:0]       r_state, w_state_nxt;
    logic [1:0]       r_op,    w_op_nxt;
    logic [WIDTH-1:0] r_fill,  w_fill_nxt;   // fill bits not yet presented
    logic [CNT_W:0]   r_len,   w_len_nxt;
    logic [CNT_W:0]   r_cnt,   w_cnt_nxt;    // RUN edges already taken

    logic             w_cmd_ready_nxt;
    logic [1:0]       w_sel_nxt;
    logic [WIDTH-1:0] w_p_in_nxt;
    logic             w_s_right_in_nxt;
    logic             w_s_left_in_nxt;
    logic             w_rsp_valid_nxt;
    logic [WIDTH-1:0] w_rsp_data_nxt;
    logic [WIDTH-1:0] w_rsp_ser_nxt;

    logic             w_accept;
    logic             w_cmd_is_shift;
    logic             w_cmd_len_zero;
    logic             w_op_is_shift;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W:0]   w_run_len;
    logic             w_run_last;

    assign w_accept       = (r_state == S_IDLE) && cmd_valid && cmd_ready;
    assign w_cmd_is_shift = cmd_op[0] ^ cmd_op[1];
    assign w_cmd_len_zero = (cmd_len == '0);
    assign w_op_is_shift  = r_op[0] ^ r_op[1];
    assign w_cnt_inc      = r_cnt + C_CNT_ONE;
    // Hold and load occupy exactly one RUN cycle.
    assign w_run_len      = w_op_is_shift ? r_len : C_CNT_ONE;
    assign w_run_last     = (w_cnt_inc == w_run_len);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_HOLD;
            r_fill     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            cmd_ready  <= 1'b1;
            sel        <= OP_HOLD;
            p_in       <= '0;
            s_right_in <= 1'b0;
            s_left_in  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ser    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_fill     <= w_fill_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            cmd_ready  <= w_cmd_ready_nxt;
            sel        <= w_sel_nxt;
            p_in       <= w_p_in_nxt;
            s_right_in <= w_s_right_in_nxt;
            s_left_in  <= w_s_left_in_nxt;
            rsp_valid  <= w_rsp_valid_nxt;
            rsp_data   <= w_rsp_data_nxt;
            rsp_ser    <= w_rsp_ser_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_cmd_is_shift && w_cmd_len_zero) ? S_SETTLE : S_RUN;
                end
            end
            S_RUN:    if (w_run_last) w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-output logic. Register controls default to idle values every
    // cycle so p_in and the serial inputs are only ever non-zero while the
    // matching sel is being driven.
    // ------------------------------------------------------------------
    always_comb begin
        w_op_nxt         = r_op;
        w_fill_nxt       = r_fill;
        w_len_nxt        = r_len;
        w_cnt_nxt        = r_cnt;
        w_cmd_ready_nxt  = cmd_ready;
        w_sel_nxt        = OP_HOLD;
        w_p_in_nxt       = '0;
        w_s_right_in_nxt = 1'b0;
        w_s_left_in_nxt  = 1'b0;
        w_rsp_valid_nxt  = rsp_valid;
        w_rsp_data_nxt   = rsp_data;
        w_rsp_ser_nxt    = rsp_ser;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt        = cmd_op;
                    w_len_nxt       = {1'b0, cmd_len};
                    w_cnt_nxt       = '0;
                    w_fill_nxt      = cmd_data >> 1;
                    w_rsp_ser_nxt   = '0;
                    w_cmd_ready_nxt = 1'b0;
                    // Present the first cycle's controls straight away.
                    case (cmd_op)
                        OP_LOAD: begin
                            w_sel_nxt  = OP_LOAD;
                            w_p_in_nxt = cmd_data;
                        end
                        OP_SHR: begin
                            if (!w_cmd_len_zero) begin
                                w_sel_nxt        = OP_SHR;
                                w_s_right_in_nxt = cmd_data[0];
                            end
                        end
                        OP_SHL: begin
                            if (!w_cmd_len_zero) begin
                                w_sel_nxt       = OP_SHL;
                                w_s_left_in_nxt = cmd_data[0];
                            end
                        end
                        default: w_sel_nxt = OP_HOLD;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                // The serial output seen at this edge is the bit leaving.
                if (r_op == OP_SHR) begin
                    w_rsp_ser_nxt = {rsp_ser[WIDTH-2:0], s_right_out};
                end else if (r_op == OP_SHL) begin
                    w_rsp_ser_nxt = {rsp_ser[WIDTH-2:0], s_left_out};
                end
                if (!w_run_last) begin
                    // Only shifts run longer than one cycle; fill drains to 0.
                    w_sel_nxt  = r_op;
                    w_fill_nxt = r_fill >> 1;
                    if (r_op == OP_SHR) w_s_right_in_nxt = r_fill[0];
                    if (r_op == OP_SHL) w_s_left_in_nxt  = r_fill[0];
                end
            end
            S_SETTLE: begin
                w_rsp_data_nxt  = p_out;
                w_rsp_valid_nxt = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_usr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usr_cmd_sequencer
//  Purpose  : Self-checking bench for usr_cmd_sequencer with a behavioural
//             shift-register environment and a command-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usr_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_len;
    logic [1:0] sel;
    logic [3:0] p_in;
    logic       s_right_in;
    logic       s_left_in;
    logic [3:0] p_out;
    logic       s_right_out;
    logic       s_left_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [3:0] rsp_ser;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_reg;   // reference model's view of the register contents

    usr_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .sel(sel), .p_in(p_in), .s_right_in(s_right_in), .s_left_in(s_left_in),
        .p_out(p_out), .s_right_out(s_right_out), .s_left_out(s_left_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ser(rsp_ser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: the universal shift register being controlled.
    always_ff @(posedge clk) begin
        if (rst) p_out <= 4'b0000;
        else begin
            case (sel)
                2'b01:   p_out <= {s_right_in, p_out[3:1]};
                2'b10:   p_out <= {p_out[2:0], s_left_in};
                2'b11:   p_out <= p_in;
                default: p_out <= p_out;
            endcase
        end
    end
    assign s_right_out = p_out[0];
    assign s_left_out  = p_out[3];

    // Command-level reference: final word, shifted-out bits, latency,
    // number of active sel cycles and the fill-bit sequence.
    function automatic void ref_cmd(input logic [1:0] op, input logic [3:0] data,
                                    input logic [2:0] len, output logic [3:0] rd,
                                    output logic [3:0] rs, output int lat,
                                    output int nsel, output logic [7:0] seq);
        logic [3:0] t;
        logic b, o;
        rs = 4'b0000; seq = 8'h00;
        case (op)
            2'b11: begin exp_reg = data; lat = 2; nsel = 1; end
            2'b00: begin lat = 2; nsel = 0; end
            default: begin
                lat = int'(len) + 1; nsel = int'(len);
                for (int i = 0; i < int'(len); i++) begin
                    t = data >> i;
                    b = t[0];
                    seq[i] = b;
                    if (op == 2'b01) begin o = exp_reg[0]; exp_reg = {b, exp_reg[3:1]}; end
                    else             begin o = exp_reg[3]; exp_reg = {exp_reg[2:0], b}; end
                    rs = {rs[2:0], o};
                end
            end
        endcase
        rd = exp_reg;
    endfunction

    // Issues one command and observes it up to rsp_valid (rsp_ready left 0).
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] len,
                          output int lat, output logic [3:0] rd, output logic [3:0] rs,
                          output int nsel, output logic [7:0] seq, output bit side_bad);
        int guard;
        int k;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = len;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_data = 4'($urandom); cmd_len = 3'($urandom);
        lat = 0; nsel = 0; seq = 8'h00; side_bad = 1'b0; k = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (cmd_ready !== 1'b0) side_bad = 1'b1;
            if (sel !== 2'b00) begin
                nsel++;
                if (sel !== op) side_bad = 1'b1;
                if (k < 8) seq[k] = (op == 2'b10) ? s_left_in : s_right_in;
                k++;
            end
            if (sel !== 2'b01 && s_right_in !== 1'b0) side_bad = 1'b1;
            if (sel !== 2'b10 && s_left_in  !== 1'b0) side_bad = 1'b1;
            if (sel !== 2'b11 && p_in !== 4'b0000)    side_bad = 1'b1;
            @(posedge clk); lat++; @(negedge clk);
        end
        rd = rsp_data; rs = rsp_ser;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 2'b00; cmd_data = 4'h0; cmd_len = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_reg = 4'b0000;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (sel !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b exp=00", sel); end
        total++; if ({p_in, s_right_in, s_left_in} !== 6'b0) begin bad++; $display("FAIL reset_reg_inputs got=%b exp=0", {p_in, s_right_in, s_left_in}); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({rsp_data, rsp_ser} !== 8'h00) begin bad++; $display("FAIL reset_rsp got=%h exp=00", {rsp_data, rsp_ser}); end
    endtask

    task automatic test_load();
        int lat, nsel; logic [3:0] rd, rs; logic [7:0] seq; bit sb;
        do_cmd(2'b11, 4'b1001, 3'd0, lat, rd, rs, nsel, seq, sb);
        exp_reg = 4'b1001;
        total++; if (lat !== 2) begin bad++; $display("FAIL load_latency got=%0d exp=2", lat); end
        total++; if (nsel !== 1) begin bad++; $display("FAIL load_sel_cycles got=%0d exp=1", nsel); end
        total++; if (rd !== 4'b1001) begin bad++; $display("FAIL load_rsp_data got=%b exp=1001", rd); end
        total++; if (rs !== 4'b0000) begin bad++; $display("FAIL load_rsp_ser got=%b exp=0000", rs); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL load_controls got=%b exp=0", sb); end
        handshake();
        total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL load_release got=%b exp=01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_shift_right();
        int lat, nsel; logic [3:0] rd, rs; logic [7:0] seq; bit sb;
        do_cmd(2'b11, 4'b1001, 3'd0, lat, rd, rs, nsel, seq, sb);
        handshake();
        do_cmd(2'b01, 4'b0110, 3'd4, lat, rd, rs, nsel, seq, sb);
        exp_reg = 4'b0110;
        total++; if (lat !== 5) begin bad++; $display("FAIL shr_latency got=%0d exp=5", lat); end
        total++; if (nsel !== 4) begin bad++; $display("FAIL shr_sel_cycles got=%0d exp=4", nsel); end
        total++; if (seq[3:0] !== 4'b0110) begin bad++; $display("FAIL shr_fill_seq got=%b exp=0110", seq[3:0]); end
        total++; if (rd !== 4'b0110) begin bad++; $display("FAIL shr_rsp_data got=%b exp=0110", rd); end
        total++; if (rs !== 4'b1001) begin bad++; $display("FAIL shr_rsp_ser got=%b exp=1001", rs); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL shr_controls got=%b exp=0", sb); end
        handshake();
    endtask

    task automatic test_shift_left();
        int lat, nsel; logic [3:0] rd, rs; logic [7:0] seq; bit sb;
        do_cmd(2'b11, 4'b1001, 3'd0, lat, rd, rs, nsel, seq, sb);
        handshake();
        do_cmd(2'b10, 4'b0011, 3'd2, lat, rd, rs, nsel, seq, sb);
        exp_reg = 4'b0111;
        total++; if (lat !== 3) begin bad++; $display("FAIL shl_latency got=%0d exp=3", lat); end
        total++; if (seq[1:0] !== 2'b11 || nsel !== 2) begin bad++; $display("FAIL shl_fill got=%b/%0d exp=11/2", seq[1:0], nsel); end
        total++; if (rd !== 4'b0111) begin bad++; $display("FAIL shl_rsp_data got=%b exp=0111", rd); end
        total++; if (rs !== 4'b0010) begin bad++; $display("FAIL shl_rsp_ser got=%b exp=0010", rs); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL shl_controls got=%b exp=0", sb); end
        handshake();
    endtask

    task automatic test_len0();
        int lat, nsel; logic [3:0] rd, rs; logic [7:0] seq; bit sb;
        logic [3:0] prior;
        prior = exp_reg;
        do_cmd(2'b01, 4'b1111, 3'd0, lat, rd, rs, nsel, seq, sb);
        total++; if (lat !== 1) begin bad++; $display("FAIL len0_latency got=%0d exp=1", lat); end
        total++; if (nsel !== 0) begin bad++; $display("FAIL len0_sel_cycles got=%0d exp=0", nsel); end
        total++; if (rd !== prior) begin bad++; $display("FAIL len0_rsp_data got=%b exp=%b", rd, prior); end
        total++; if (rs !== 4'b0000 || sb !== 1'b0) begin bad++; $display("FAIL len0_ser_ctrl got=%b/%b exp=0000/0", rs, sb); end
        handshake();
    endtask

    task automatic test_len7();
        int lat, nsel, e_lat, e_nsel; logic [3:0] rd, rs, e_rd, e_rs; logic [7:0] seq, e_seq; bit sb;
        ref_cmd(2'b11, 4'b1011, 3'd0, e_rd, e_rs, e_lat, e_nsel, e_seq);
        do_cmd(2'b11, 4'b1011, 3'd0, lat, rd, rs, nsel, seq, sb);
        handshake();
        ref_cmd(2'b01, 4'b1101, 3'd7, e_rd, e_rs, e_lat, e_nsel, e_seq);
        do_cmd(2'b01, 4'b1101, 3'd7, lat, rd, rs, nsel, seq, sb);
        total++; if (lat !== 8) begin bad++; $display("FAIL len7_latency got=%0d exp=8", lat); end
        total++; if (nsel !== 7) begin bad++; $display("FAIL len7_sel_cycles got=%0d exp=7", nsel); end
        total++; if (seq[6:0] !== 7'b0001101) begin bad++; $display("FAIL len7_fill_seq got=%b exp=0001101", seq[6:0]); end
        total++; if (rd !== e_rd) begin bad++; $display("FAIL len7_rsp_data got=%b exp=%b", rd, e_rd); end
        total++; if (rs !== e_rs) begin bad++; $display("FAIL len7_rsp_ser got=%b exp=%b", rs, e_rs); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL len7_controls got=%b exp=0", sb); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat, nsel, guard; logic [3:0] rd, rs; logic [7:0] seq; bit sb, moved;
        do_cmd(2'b11, 4'b0101, 3'd0, lat, rd, rs, nsel, seq, sb);
        exp_reg = 4'b0101;
        moved = 1'b0;
        // A competing command is presented while the response is stalled.
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1110; cmd_len = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== rd || rsp_ser !== rs ||
                cmd_ready !== 1'b0 || sel !== 2'b00) moved = 1'b1;
        end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL bp_stable got=%b exp=0", moved); end
        total++; if (rd !== 4'b0101) begin bad++; $display("FAIL bp_rsp_data got=%b exp=0101", rd); end
        handshake();
        total++; if ({rsp_valid, cmd_ready, p_out} !== {2'b01, 4'b0101}) begin bad++; $display("FAIL bp_release got=%b exp=010101", {rsp_valid, cmd_ready, p_out}); end
        @(posedge clk); @(negedge clk);
        total++; if ({cmd_ready, sel} !== 3'b011) begin bad++; $display("FAIL bp_next_accept got=%b exp=011", {cmd_ready, sel}); end
        cmd_valid = 1'b0;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 10) begin @(posedge clk); @(negedge clk); guard++; end
        exp_reg = 4'b1110;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 4'b1110) begin bad++; $display("FAIL bp_second_rsp got=%b/%b exp=1/1110", rsp_valid, rsp_data); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat, nsel; logic [3:0] rd, rs; logic [7:0] seq; bit sb, seen;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'b1011; cmd_len = 3'd4;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        exp_reg = 4'b0000;
        total++; if ({cmd_ready, sel} !== 3'b100) begin bad++; $display("FAIL rstmid_ctrl got=%b exp=100", {cmd_ready, sel}); end
        total++; if ({p_in, s_right_in, s_left_in} !== 6'b0) begin bad++; $display("FAIL rstmid_reg_inputs got=%b exp=0", {p_in, s_right_in, s_left_in}); end
        total++; if ({rsp_valid, rsp_data, rsp_ser} !== 9'b0) begin bad++; $display("FAIL rstmid_rsp got=%b exp=0", {rsp_valid, rsp_data, rsp_ser}); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid !== 1'b0 || sel !== 2'b00) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_dropped got=%b exp=0", seen); end
        do_cmd(2'b11, 4'b0110, 3'd0, lat, rd, rs, nsel, seq, sb);
        exp_reg = 4'b0110;
        total++; if (lat !== 2 || rd !== 4'b0110) begin bad++; $display("FAIL rstmid_recover got=%0d/%b exp=2/0110", lat, rd); end
        handshake();
    endtask

    task automatic test_random();
        int lat, nsel, e_lat, e_nsel; logic [3:0] rd, rs, e_rd, e_rs; logic [7:0] seq, e_seq; bit sb;
        logic [1:0] op; logic [3:0] data; logic [2:0] len;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3)); data = 4'($urandom); len = 3'($urandom_range(0, 7));
            ref_cmd(op, data, len, e_rd, e_rs, e_lat, e_nsel, e_seq);
            do_cmd(op, data, len, lat, rd, rs, nsel, seq, sb);
            total++; if (lat !== e_lat) begin bad++; $display("FAIL rnd%0d_latency op=%b len=%0d got=%0d exp=%0d", n, op, len, lat, e_lat); end
            total++; if (nsel !== e_nsel || (op[0] ^ op[1] && seq !== e_seq)) begin bad++; $display("FAIL rnd%0d_seq op=%b got=%0d/%b exp=%0d/%b", n, op, nsel, seq, e_nsel, e_seq); end
            total++; if (rd !== e_rd) begin bad++; $display("FAIL rnd%0d_rsp_data op=%b got=%b exp=%b", n, op, rd, e_rd); end
            total++; if (rs !== e_rs) begin bad++; $display("FAIL rnd%0d_rsp_ser op=%b got=%b exp=%b", n, op, rs, e_rs); end
            total++; if (sb !== 1'b0) begin bad++; $display("FAIL rnd%0d_controls got=%b exp=0", n, sb); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
            handshake();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load();
        test_shift_right();
        test_shift_left();
        test_len0();
        test_len7();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
